// File: rtl/cla_seq_arbiter.sv
// cla_seq_arbiter
// ---------------
// Shares one 4-bit carry-lookahead adder between two requesters. A WIDTH-bit
// add is done one nibble per cycle, least-significant nibble first. The carry
// between nibbles is held in a register.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req0/req1                   level requests, held until the matching done
//   a0,b0,cin0 / a1,b1,cin1     operands per requester, sampled at accept
//   gnt0/gnt1                   requester owns the adder (RUN and DONE)
//   busy                        RUN or DONE
//   sum, cout, ovf              result; held after DONE until next accept
//   done0/done1                 one-cycle result-valid pulse to the owner

module CLA_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout,
    output logic       PG,
    output logic       GG
);
    logic [3:0] g, p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Expanded lookahead carries
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign S    = p ^ c[3:0];
    assign Cout = c[4];
    assign PG   = &p;
    assign GG   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

module cla_seq_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             done0,
    output logic             done1
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic             owner;
    logic             last;

    logic [3:0]       a_nib, b_nib, s_nib;
    logic             c_out;
    logic             pg_unused, gg_unused;
    logic             pick1;
    logic             last_nib;

    // Requester 1 wins if it is alone, or on a tie when 0 was served last.
    assign pick1    = req1 & (~req0 | ~last);
    assign last_nib = (k == KW'(NIB - 1));

    assign a_nib = 4'(opa >> {k, 2'b00});
    assign b_nib = 4'(opb >> {k, 2'b00});

    CLA_4bit u_cla (
        .A    (a_nib),
        .B    (b_nib),
        .Cin  (carry),
        .S    (s_nib),
        .Cout (c_out),
        .PG   (pg_unused),
        .GG   (gg_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            owner <= 1'b0;
            last  <= 1'b1;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        owner <= pick1;
                        last  <= pick1;
                        opa   <= pick1 ? a1 : a0;
                        opb   <= pick1 ? b1 : b0;
                        carry <= pick1 ? cin1 : cin0;
                        k     <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[{k, 2'b00} +: 4] <= s_nib;
                    carry <= c_out;
                    if (last_nib) begin
                        cout  <= c_out;
                        // Carry into the MSB is a^b^s of bit 3 of the top nibble.
                        ovf   <= opa[WIDTH-1] ^ opb[WIDTH-1] ^ s_nib[3] ^ c_out;
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == RUN) || (state == DONE);
    assign gnt0  = busy & ~owner;
    assign gnt1  = busy & owner;
    assign done0 = (state == DONE) & ~owner;
    assign done1 = (state == DONE) & owner;
endmodule
